fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl.sv | 92 +++++++++
 tb/tb_fifo_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller for an external register file.
// Tracks head/tail pointers, entry count, status/threshold flags and sticky error flags.
module fifo_ctrl #(
  parameter int no_of_words   = 3,
  parameter int almost_margin = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic                   rd,
  output logic                   w_en,
  output logic [no_of_words-1:0] write_address,
  output logic [no_of_words-1:0] read_address,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [no_of_words:0]   count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam logic [no_of_words:0] DEPTH_C = {1'b1, {no_of_words{1'b0}}};
  localparam logic [no_of_words:0] AE_TH   = (no_of_words+1)'(almost_margin);
  localparam logic [no_of_words:0] AF_TH   = DEPTH_C - AE_TH;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    POP  = 2'b01,
    PUSH = 2'b10,
    BOTH = 2'b11
  } op_t;

  logic                   push;
  logic                   pop;
  op_t                    op;
  logic [no_of_words-1:0] wa_nxt;
  logic [no_of_words-1:0] ra_nxt;
  logic [no_of_words:0]   cnt_nxt;

  // A write while full is still accepted when the same cycle frees a slot.
  assign push = wr & (~full | rd);
  assign pop  = rd & ~empty;
  assign w_en = push;
  assign op   = op_t'({push, pop});

  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  always_comb begin
    wa_nxt  = write_address;
    ra_nxt  = read_address;
    cnt_nxt = count;
    case (op)
      PUSH: begin
        wa_nxt  = write_address + 1'b1;
        cnt_nxt = count + 1'b1;
      end
      POP: begin
        ra_nxt  = read_address + 1'b1;
        cnt_nxt = count - 1'b1;
      end
      BOTH: begin
        wa_nxt = write_address + 1'b1;
        ra_nxt = read_address + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_address <= '0;
      read_address  <= '0;
      count         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      write_address <= wa_nxt;
      read_address  <= ra_nxt;
      count         <= cnt_nxt;
      // Flags are derived from the next count so they never lag it.
      full          <= (cnt_nxt == DEPTH_C);
      empty         <= (cnt_nxt == '0);
      overflow      <= overflow | (wr & ~push);
      underflow     <= underflow | (rd & ~pop);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios plus random traffic, checked against a
// queue-based occupancy model with a bench-side register file for data order.
module tb_fifo_ctrl;

  localparam int NW    = 3;
  localparam int DEPTH = 8;
  localparam int AM    = 1;

  logic          clk = 1'b0;
  logic          reset, wr, rd;
  logic          w_en, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [NW-1:0] write_address, read_address;
  logic [NW:0]   count;

  logic [7:0] mem [DEPTH];
  logic [7:0] wdata;
  logic [7:0] rdata;

  int checks   = 0;
  int failures = 0;

  // reference model
  int       q[$];
  int       m_wp, m_rp;
  bit       m_ovf, m_udf;

  fifo_ctrl #(.no_of_words(NW), .almost_margin(AM)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .w_en(w_en),
    .write_address(write_address), .read_address(read_address),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (w_en) mem[write_address] <= wdata;
  assign rdata = mem[read_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(count), 32'(q.size()));
    chk("wa", 32'(write_address), 32'(m_wp));
    chk("ra", 32'(read_address), 32'(m_rp));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("afull", 32'(almost_full), 32'(q.size() >= DEPTH - AM));
    chk("aempty", 32'(almost_empty), 32'(q.size() <= AM));
    chk("ovf", 32'(overflow), 32'(m_ovf));
    chk("udf", 32'(underflow), 32'(m_udf));
  endtask

  // One cycle: drive at negedge, check combinational outputs, clock, check state.
  task automatic step(input bit w, input bit r, input bit rs);
    bit p_push, p_pop;
    wr = w; rd = r; reset = rs; wdata = 8'($urandom);
    #1;
    p_push = w && (q.size() < DEPTH || r);
    p_pop  = r && (q.size() > 0);
    chk("w_en", 32'(w_en), 32'(p_push));
    if (!rs && p_pop) chk("rdata", 32'(rdata), 32'(q[0]));
    @(posedge clk);
    if (rs) begin
      q.delete(); m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
    end else begin
      if (p_pop) begin void'(q.pop_front()); m_rp = (m_rp + 1) % DEPTH; end
      if (p_push) begin q.push_back(int'(wdata)); m_wp = (m_wp + 1) % DEPTH; end
      if (w && !p_push) m_ovf = 1;
      if (r && !p_pop) m_udf = 1;
    end
    @(negedge clk);
    check_state();
  endtask

  initial begin
    wr = 0; rd = 0; reset = 1; wdata = 0;
    m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
    @(negedge clk);
    step(0, 0, 1);
    step(1, 1, 1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_afull", 32'(almost_full), 32'd0);

    // Fill to full; almost_full rises at count 7.
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    chk("af_at7", 32'(almost_full), 32'd1);
    step(1, 0, 0);
    chk("wrap_wa", 32'(write_address), 32'd0);
    chk("full8", 32'(full), 32'd1);
    chk("cnt8", 32'(count), 32'd8);

    // Rejected push while full; overflow stays sticky.
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Simultaneous push/pop while full.
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    chk("both_wa", 32'(write_address), 32'd4);
    chk("both_ra", 32'(read_address), 32'd4);
    chk("both_cnt", 32'(count), 32'd8);

    // Push/pop while empty: write accepted, read rejected.
    step(0, 0, 1);
    step(1, 1, 0);
    chk("e_ra", 32'(read_address), 32'd0);
    chk("e_cnt", 32'(count), 32'd1);
    chk("e_udf", 32'(underflow), 32'd1);

    // Pointer wrap with data ordering.
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    chk("w_wa", 32'(write_address), 32'd3);
    chk("w_ra", 32'(read_address), 32'd5);
    chk("w_cnt", 32'(count), 32'd6);
    for (int i = 0; i < 6; i++) step(0, 1, 0);

    // Reset mid-burst discards contents.
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(1, 0, 1);
    chk("mr_cnt", 32'(count), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_wa", 32'(write_address), 32'd0);

    // Random traffic with varying bias and occasional reset.
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i / 50) % 3;
      step(($urandom_range(0, 3) < 1 + bias) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) < 3 - bias) ? 1'b1 : 1'b0,
           ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
